// File: rtl/page_splitter.sv
// page_splitter: cuts a host AXI4-Stream into fixed-size pages, tags each page
// end with tlast and emits one {index, byte count, last} record per page on a
// first-word-fall-through metadata FIFO. A 2-entry skid buffer decouples the
// input handshake from the downstream ready.
module page_splitter #(
  parameter int AXI_DATA_BITS = 512,
  parameter int PAGE_BYTES    = 4096,
  parameter int META_DEPTH    = 4,
  parameter int IDX_BITS      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_DATA_BITS-1:0]      i_tdata,
  input  logic [AXI_DATA_BITS/8-1:0]    i_tkeep,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [AXI_DATA_BITS-1:0]      o_tdata,
  output logic [AXI_DATA_BITS/8-1:0]    o_tkeep,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic [IDX_BITS-1:0]           o_meta_idx,
  output logic [$clog2(PAGE_BYTES):0]   o_meta_bytes,
  output logic                          o_meta_last,
  output logic                          o_meta_valid,
  input  logic                          o_meta_ready
);

  localparam int BPB        = AXI_DATA_BITS / 8;
  localparam int PAGE_BEATS = PAGE_BYTES / BPB;
  localparam int BEAT_W     = (PAGE_BEATS > 1) ? $clog2(PAGE_BEATS) : 1;
  localparam int BYTE_W     = $clog2(PAGE_BYTES) + 1;
  localparam int MPTR_W     = $clog2(META_DEPTH);
  localparam int MCNT_W     = MPTR_W + 1;

  // Page counting state
  logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [BYTE_W-1:0]        byte_acc_q, byte_acc_d;
  logic [IDX_BITS-1:0]      page_idx_q, page_idx_d;

  // Skid buffer: two entries addressed by 1-bit pointers
  logic [AXI_DATA_BITS-1:0] skid_data_q [2];
  logic [AXI_DATA_BITS-1:0] skid_data_d [2];
  logic [BPB-1:0]           skid_keep_q [2];
  logic [BPB-1:0]           skid_keep_d [2];
  logic [1:0]               skid_last_q, skid_last_d;
  logic                     skid_wr_q, skid_wr_d;
  logic                     skid_rd_q, skid_rd_d;
  logic [1:0]               skid_cnt_q, skid_cnt_d;

  // Metadata FIFO storage and pointers
  logic [IDX_BITS-1:0]      meta_idx_q   [META_DEPTH];
  logic [IDX_BITS-1:0]      meta_idx_d   [META_DEPTH];
  logic [BYTE_W-1:0]        meta_bytes_q [META_DEPTH];
  logic [BYTE_W-1:0]        meta_bytes_d [META_DEPTH];
  logic [META_DEPTH-1:0]    meta_last_q, meta_last_d;
  logic [MPTR_W-1:0]        meta_wr_q, meta_wr_d;
  logic [MPTR_W-1:0]        meta_rd_q, meta_rd_d;
  logic [MCNT_W-1:0]        meta_cnt_q, meta_cnt_d;

  // Handshake and control terms
  logic [BYTE_W-1:0]        keep_bytes;
  logic                     page_close;
  logic                     skid_full;
  logic                     meta_full;
  logic                     meta_pop;
  logic                     meta_push;
  logic                     stall_close;
  logic                     in_fire;
  logic                     out_fire;

  // Count the set tkeep bits of the presented beat
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < BPB; i++) begin
      keep_bytes = keep_bytes + BYTE_W'(i_tkeep[i]);
    end
  end

  // Handshake decisions; a closing beat is held off while the metadata FIFO
  // has no room, unless a pop in the same cycle frees a slot
  always_comb begin
    page_close   = (beat_cnt_q == BEAT_W'(PAGE_BEATS - 1)) || i_tlast;
    skid_full    = (skid_cnt_q == 2'd2);
    meta_full    = (meta_cnt_q == MCNT_W'(META_DEPTH));
    o_tvalid     = rst_n && (skid_cnt_q != 2'd0);
    o_meta_valid = rst_n && (meta_cnt_q != '0);
    meta_pop     = o_meta_valid && o_meta_ready;
    stall_close  = i_tvalid && page_close && meta_full && !meta_pop;
    i_tready     = rst_n && !skid_full && !stall_close;
    in_fire      = i_tvalid && i_tready;
    out_fire     = o_tvalid && o_tready;
    meta_push    = in_fire && page_close;
  end

  // Outputs come straight from registered storage, so they hold while stalled
  always_comb begin
    o_tdata      = skid_data_q[skid_rd_q];
    o_tkeep      = skid_keep_q[skid_rd_q];
    o_tlast      = skid_last_q[skid_rd_q];
    o_meta_idx   = meta_idx_q[meta_rd_q];
    o_meta_bytes = meta_bytes_q[meta_rd_q];
    o_meta_last  = meta_last_q[meta_rd_q];
  end

  // Next-state for page counters, skid buffer and metadata FIFO
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    byte_acc_d   = byte_acc_q;
    page_idx_d   = page_idx_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;
    skid_wr_d    = skid_wr_q;
    skid_rd_d    = skid_rd_q;
    skid_cnt_d   = skid_cnt_q;
    meta_idx_d   = meta_idx_q;
    meta_bytes_d = meta_bytes_q;
    meta_last_d  = meta_last_q;
    meta_wr_d    = meta_wr_q;
    meta_rd_d    = meta_rd_q;
    meta_cnt_d   = meta_cnt_q;

    if (in_fire) begin
      skid_data_d[skid_wr_q] = i_tdata;
      skid_keep_d[skid_wr_q] = i_tkeep;
      skid_last_d[skid_wr_q] = page_close;
      skid_wr_d              = ~skid_wr_q;
      if (page_close) begin
        beat_cnt_d = '0;
        byte_acc_d = '0;
        page_idx_d = i_tlast ? '0 : page_idx_q + IDX_BITS'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        byte_acc_d = byte_acc_q + keep_bytes;
      end
    end

    if (out_fire) begin
      skid_rd_d = ~skid_rd_q;
    end

    case ({in_fire, out_fire})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase

    if (meta_push) begin
      meta_idx_d[meta_wr_q]   = page_idx_q;
      meta_bytes_d[meta_wr_q] = byte_acc_q + keep_bytes;
      meta_last_d[meta_wr_q]  = i_tlast;
      meta_wr_d               = meta_wr_q + MPTR_W'(1);
    end

    if (meta_pop) begin
      meta_rd_d = meta_rd_q + MPTR_W'(1);
    end

    case ({meta_push, meta_pop})
      2'b10:   meta_cnt_d = meta_cnt_q + MCNT_W'(1);
      2'b01:   meta_cnt_d = meta_cnt_q - MCNT_W'(1);
      default: meta_cnt_d = meta_cnt_q;
    endcase
  end

  // Control state with synchronous reset; reset drops partial pages and queued records
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      byte_acc_q <= '0;
      page_idx_q <= '0;
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      meta_wr_q  <= '0;
      meta_rd_q  <= '0;
      meta_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      byte_acc_q <= byte_acc_d;
      page_idx_q <= page_idx_d;
      skid_wr_q  <= skid_wr_d;
      skid_rd_q  <= skid_rd_d;
      skid_cnt_q <= skid_cnt_d;
      meta_wr_q  <= meta_wr_d;
      meta_rd_q  <= meta_rd_d;
      meta_cnt_q <= meta_cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the counters above
  always_ff @(posedge clk) begin
    skid_data_q  <= skid_data_d;
    skid_keep_q  <= skid_keep_d;
    skid_last_q  <= skid_last_d;
    meta_idx_q   <= meta_idx_d;
    meta_bytes_q <= meta_bytes_d;
    meta_last_q  <= meta_last_d;
  end

endmodule

// File: tb/tb_page_splitter.sv
// tb_page_splitter: directed tests for page_splitter with default parameters
// (512-bit beats, 4096-byte pages, 4-deep metadata FIFO).
`timescale 1ns/1ps
module tb_page_splitter;

  localparam int DW         = 512;
  localparam int BPB        = 64;
  localparam int PAGE_BEATS = 64;
  localparam int IW         = 32;
  localparam int BW         = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   i_tdata;
  logic [BPB-1:0]  i_tkeep;
  logic            i_tlast;
  logic            i_tvalid;
  logic            i_tready;
  logic [DW-1:0]   o_tdata;
  logic [BPB-1:0]  o_tkeep;
  logic            o_tlast;
  logic            o_tvalid;
  logic            o_tready;
  logic [IW-1:0]   o_meta_idx;
  logic [BW-1:0]   o_meta_bytes;
  logic            o_meta_last;
  logic            o_meta_valid;
  logic            o_meta_ready;

  page_splitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tdata      (i_tdata),
    .i_tkeep      (i_tkeep),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tkeep      (o_tkeep),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .o_meta_idx   (o_meta_idx),
    .o_meta_bytes (o_meta_bytes),
    .o_meta_last  (o_meta_last),
    .o_meta_valid (o_meta_valid),
    .o_meta_ready (o_meta_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPB-1:0] keep;
    logic           last;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [BW-1:0] bytes;
    logic          last;
  } meta_t;

  beat_t exp_beats [$];
  meta_t exp_meta  [$];

  int  errors     = 0;
  int  checks     = 0;
  int  m_beat     = 0;
  int  accepted   = 0;
  int  out_beats  = 0;
  int  out_tlasts = 0;
  int  meta_seen  = 0;
  bit  rand_ready = 1'b0;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected output beat for an accepted input beat; tlast on page end or transfer end
  task automatic model_accept(input logic [DW-1:0] data, input logic [BPB-1:0] keep, input logic last);
    beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = (m_beat == PAGE_BEATS - 1) || last;
    exp_beats.push_back(b);
    m_beat = b.last ? 0 : m_beat + 1;
    accepted++;
  endtask

  task automatic push_meta(input int idx, input int bytes, input logic last);
    meta_t m;
    m.idx   = IW'(idx);
    m.bytes = BW'(bytes);
    m.last  = last;
    exp_meta.push_back(m);
  endtask

  // Present one beat and hold it until accepted (bounded wait); called at posedge+1
  task automatic applyStimulus(input logic [DW-1:0] data, input logic [BPB-1:0] keep, input logic last);
    bit done;
    done     = 1'b0;
    i_tdata  = data;
    i_tkeep  = keep;
    i_tlast  = last;
    i_tvalid = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (i_tready) begin
        done = 1'b1;
        model_accept(data, keep, last);
      end
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    checkOutput("beat_accepted", DW'(done), DW'(1));
  endtask

  // Send nbytes as full beats plus a trailing partial beat, optional idle gaps
  task automatic send_transfer(input int nbytes, input int idle_max, input logic with_last);
    int beats;
    beats = (nbytes + BPB - 1) / BPB;
    for (int b = 0; b < beats; b++) begin
      int             nb;
      int             gap;
      logic [BPB-1:0] keep;
      logic [DW-1:0]  data;
      nb   = (nbytes - b * BPB > BPB) ? BPB : nbytes - b * BPB;
      keep = '0;
      for (int k = 0; k < nb; k++) keep[k] = 1'b1;
      for (int w = 0; w < DW / 32; w++) data[w*32 +: 32] = $urandom;
      gap = (idle_max > 0) ? $urandom_range(0, idle_max) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(data, keep, with_last && (b == beats - 1));
    end
  endtask

  // Wait (bounded) until every expected beat and record has been seen
  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_beats.size() != 0 || exp_meta.size() != 0) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_beats", DW'(exp_beats.size()), DW'(0));
    checkOutput("drain_meta", DW'(exp_meta.size()), DW'(0));
  endtask

  // Random downstream ready for the backpressure test
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      o_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Page stream monitor: order/content check and hold-while-stalled check
  logic [DW-1:0]  prev_data;
  logic [BPB-1:0] prev_keep;
  logic           prev_last;
  bit             prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      checkOutput("hold_tdata", o_tdata, prev_data);
      checkOutput("hold_tkeep", DW'(o_tkeep), DW'(prev_keep));
      checkOutput("hold_tlast", DW'(o_tlast), DW'(prev_last));
    end
    prev_stall = rst_n && o_tvalid && !o_tready;
    prev_data  = o_tdata;
    prev_keep  = o_tkeep;
    prev_last  = o_tlast;
    if (rst_n && o_tvalid && o_tready) begin
      out_beats++;
      if (o_tlast) out_tlasts++;
      if (exp_beats.size() == 0) begin
        checkOutput("beat_expected", DW'(exp_beats.size()), DW'(1));
      end else begin
        beat_t e;
        e = exp_beats.pop_front();
        checkOutput("tdata", o_tdata, e.data);
        checkOutput("tkeep", DW'(o_tkeep), DW'(e.keep));
        checkOutput("tlast", DW'(o_tlast), DW'(e.last));
      end
    end
  end

  // Metadata monitor: record content and hold-while-stalled check
  logic [IW-1:0] mprev_idx;
  logic [BW-1:0] mprev_bytes;
  logic          mprev_last;
  bit            mprev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && mprev_stall) begin
      checkOutput("hold_meta_idx", DW'(o_meta_idx), DW'(mprev_idx));
      checkOutput("hold_meta_bytes", DW'(o_meta_bytes), DW'(mprev_bytes));
      checkOutput("hold_meta_last", DW'(o_meta_last), DW'(mprev_last));
    end
    mprev_stall = rst_n && o_meta_valid && !o_meta_ready;
    mprev_idx   = o_meta_idx;
    mprev_bytes = o_meta_bytes;
    mprev_last  = o_meta_last;
    if (rst_n && o_meta_valid && o_meta_ready) begin
      meta_seen++;
      if (exp_meta.size() == 0) begin
        checkOutput("meta_expected", DW'(exp_meta.size()), DW'(1));
      end else begin
        meta_t e;
        e = exp_meta.pop_front();
        checkOutput("meta_idx", DW'(o_meta_idx), DW'(e.idx));
        checkOutput("meta_bytes", DW'(o_meta_bytes), DW'(e.bytes));
        checkOutput("meta_last", DW'(o_meta_last), DW'(e.last));
      end
    end
  end

  // Overall time limit
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int m0;
    int base;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;

    rst_n        = 1'b0;
    i_tdata      = '0;
    i_tkeep      = '0;
    i_tlast      = 1'b0;
    i_tvalid     = 1'b0;
    o_tready     = 1'b1;
    o_meta_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_i_tready", DW'(i_tready), DW'(0));
    checkOutput("rst_o_tvalid", DW'(o_tvalid), DW'(0));
    checkOutput("rst_meta_valid", DW'(o_meta_valid), DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_i_tready", DW'(i_tready), DW'(1));
    checkOutput("idle_o_tvalid", DW'(o_tvalid), DW'(0));
    @(posedge clk);
    #1;

    // 1: 8192 B, tlast exactly on the second page boundary
    $display("[TB] test 1: 8192 B transfer");
    t0 = out_tlasts;
    push_meta(0, 4096, 1'b0);
    push_meta(1, 4096, 1'b1);
    send_transfer(8192, 0, 1'b1);
    wait_drain();
    checkOutput("t1_tlast_count", DW'(out_tlasts - t0), DW'(2));

    // 2: 100 B, one short page
    $display("[TB] test 2: 100 B transfer");
    t0 = out_tlasts;
    push_meta(0, 100, 1'b1);
    send_transfer(100, 0, 1'b1);
    wait_drain();
    checkOutput("t2_tlast_count", DW'(out_tlasts - t0), DW'(1));

    // 3: 4160 B, pages of 64 + 1 beats; index restarts at 0
    $display("[TB] test 3: 4160 B transfer");
    push_meta(0, 4096, 1'b0);
    push_meta(1, 64, 1'b1);
    send_transfer(4160, 0, 1'b1);
    wait_drain();

    // Empty-keep closing beat: forwarded, adds no bytes
    $display("[TB] tkeep==0 closing beat");
    push_meta(0, 64, 1'b1);
    d0 = {16{32'hA5A5_0001}};
    d1 = {16{32'h5A5A_0002}};
    applyStimulus(d0, {BPB{1'b1}}, 1'b0);
    applyStimulus(d1, '0, 1'b1);
    wait_drain();

    // 4: metadata backpressure stalls the fifth page close
    $display("[TB] test 4: metadata FIFO backpressure");
    o_meta_ready = 1'b0;
    base = accepted;
    m0   = out_beats;
    for (int p = 0; p < 6; p++) push_meta(p, 4096, p == 5);
    fork
      send_transfer(6 * 4096, 0, 1'b1);
      begin
        repeat (420) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_stall_valid", DW'(i_tvalid), DW'(1));
        checkOutput("t4_stall_ready", DW'(i_tready), DW'(0));
        checkOutput("t4_accepted", DW'(accepted - base), DW'(5 * 64 - 1));
        checkOutput("t4_meta_valid", DW'(o_meta_valid), DW'(1));
        @(posedge clk);
        #1;
        o_meta_ready = 1'b1;
      end
    join
    wait_drain();
    checkOutput("t4_beats_out", DW'(out_beats - m0), DW'(384));

    // 5: random gaps and downstream ready over three transfers
    $display("[TB] test 5: random backpressure");
    t0 = out_tlasts;
    m0 = meta_seen;
    push_meta(0, 4096, 1'b0);
    push_meta(1, 904, 1'b1);
    push_meta(0, 300, 1'b1);
    push_meta(0, 4096, 1'b1);
    rand_ready = 1'b1;
    send_transfer(5000, 2, 1'b1);
    send_transfer(300, 2, 1'b1);
    send_transfer(4096, 2, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    o_tready = 1'b1;
    wait_drain();
    checkOutput("t5_tlast_count", DW'(out_tlasts - t0), DW'(4));
    checkOutput("t5_tlast_vs_meta", DW'(out_tlasts - t0), DW'(meta_seen - m0));

    // 6: reset at beat 94 of a transfer with one record queued
    $display("[TB] test 6: reset mid-page");
    o_meta_ready = 1'b0;
    send_transfer(94 * 64, 0, 1'b0);
    o_tready = 1'b0;
    @(negedge clk);
    checkOutput("t6_pre_tvalid", DW'(o_tvalid), DW'(1));
    checkOutput("t6_pre_meta_valid", DW'(o_meta_valid), DW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_tvalid", DW'(o_tvalid), DW'(0));
    checkOutput("t6_rst_meta_valid", DW'(o_meta_valid), DW'(0));
    checkOutput("t6_rst_i_tready", DW'(i_tready), DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("t6_pending_beats", DW'(exp_beats.size()), DW'(1));
    exp_beats.delete();
    exp_meta.delete();
    m_beat       = 0;
    o_tready     = 1'b1;
    o_meta_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_post_tvalid", DW'(o_tvalid), DW'(0));
    checkOutput("t6_post_meta_valid", DW'(o_meta_valid), DW'(0));
    @(posedge clk);
    #1;
    t0 = out_tlasts;
    push_meta(0, 200, 1'b1);
    send_transfer(200, 0, 1'b1);
    wait_drain();
    checkOutput("t6_tlast_count", DW'(out_tlasts - t0), DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
